prbs_frame_checker: RTL and testbench
=====================================

PRBS_FRAME_CHECKER -- requirements
Module: prbs_frame_checker

Interface
REQ-001 The block SHALL have parameter LOSS_THRESH, default 8, meaning per-word bit-error count at or above which a word counts as bad.
REQ-002 The block SHALL have parameter LOSS_WORDS, default 4, meaning consecutive bad words that drop lock.
REQ-003 The block SHALL have port s_axi_aclk  input  1  single clock, rising edge.
REQ-004 The block SHALL have port s_axi_aresetn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port s_axis_tvalid  input  1  decrypted word valid, from the rx stage output.
REQ-006 The block SHALL have port s_axis_tready  output  1  checker ready.
REQ-007 The block SHALL have port s_axis_sof  input  1  start of frame, qualified by tvalid.
REQ-008 The block SHALL have port s_axis_tdata  input  32  decrypted PRBS word.
REQ-009 The block SHALL have port clear  input  1  synchronous counter/lock clear.
REQ-010 The block SHALL have port locked  output  1  checker in RUN state.
REQ-011 The block SHALL have port frame_count  output  16  SOF words accepted.
REQ-012 The block SHALL have port word_count  output  32  words compared.
REQ-013 The block SHALL have port err_bits  output  32  mismatched bits.
REQ-014 The block SHALL have port err_words  output  32  words with at least one mismatched bit.
REQ-015 The block SHALL have port lock_loss_count  output  16  RUN-to-IDLE drops caused by errors.

Function
REQ-016 The pattern SHALL be PRBS31, b[n] = b[n-31] XOR b[n-28]; each word packs 32 consecutive bits with the earliest bit in tdata[31].
REQ-017 A handshake SHALL occur when tvalid and tready are both high on a rising clock edge; tready SHALL be 1 except during the cycle clear is high.
REQ-018 States: IDLE (locked=0) and RUN (locked=1).
REQ-019 IDLE: a handshake with sof=1 and tdata != 0 SHALL load the seed state from tdata, increment frame_count, and go to RUN; an all-zero seed SHALL leave the state in IDLE and still increment frame_count.
REQ-020 IDLE: handshakes with sof=0 SHALL be discarded with no counter change.
REQ-021 RUN, sof=0 handshake: the predicted word is the next 32 PRBS bits from the state; err = popcount(tdata XOR predicted), 0..32.
REQ-022 On such a handshake, word_count SHALL increase by 1 and err_bits by err; err_words SHALL increase by 1 when err != 0.
REQ-023 On such a handshake, the state SHALL advance to the predicted word, never the received word (free-running, no error multiplication).
REQ-024 RUN, sof=1 handshake: the block SHALL reseed from tdata exactly as in REQ-019 with no compare; an all-zero seed SHALL go to IDLE without incrementing lock_loss_count.
REQ-025 A bad-word counter SHALL increment on each compared word with err >= LOSS_THRESH and clear on any compared word with err < LOSS_THRESH or on reseed.
REQ-026 When the bad-word counter reaches LOSS_WORDS, the block SHALL go to IDLE and increment lock_loss_count on the same edge.
REQ-027 All counters SHALL saturate at all-ones without wrapping; err_bits SHALL add with saturation.
REQ-028 Latency: counters and locked SHALL reflect a handshake on the clock edge that accepts it, i.e. be visible the cycle after.
REQ-029 clear=1 SHALL zero all counters and the bad-word counter, force IDLE, and drop tready in that cycle; clear has priority over any handshake.
REQ-030 Changing tdata or sof while tvalid=0 SHALL have no effect.

Reset
REQ-031 Asserting s_axi_aresetn low SHALL immediately force IDLE, locked=0, tready=0, all counters and state 0, regardless of clock.
REQ-032 After deassertion, tready SHALL rise on the first rising edge; a frame in progress at reset SHALL be ignored until the next SOF.

Verification
REQ-033 Reset, then SOF word 0xFFFFFFFF followed by 0x0000000E -> locked=1, frame_count=1, word_count=1, err_bits=0, err_words=0.
REQ-034 Lock with a model seed, send 100 model words with bit 5 of word 50 flipped -> word_count=100, err_bits=1, err_words=1, locked stays 1.
REQ-035 Lock, then send 4 consecutive words each with 8 flipped bits -> locked=0 the cycle after the 4th, lock_loss_count=1, err_bits=32; then 3 bad words and 1 good word -> stays locked after re-lock, bad-word counter resets.
REQ-036 Before any SOF, send words with sof=0, then SOF with tdata=0 -> counters stay 0 except frame_count=1, locked=0.
REQ-037 While locked with random tvalid gaps, pulse clear during a handshake -> tready=0 that cycle, counters zero, locked=0, the word is not counted.
REQ-038 Assert s_axi_aresetn low mid-frame between clock edges -> outputs zero asynchronously; after release, only the next SOF relocks.

Source files
------------

// File: rtl/prbs_frame_checker.sv
// -----------------------------------------------------------------------------
// prbs_frame_checker
//
// Checks a stream of decrypted PRBS31 words (b[n] = b[n-31] ^ b[n-28], earliest
// bit of each 32-bit word in tdata[31]). An SOF word seeds the local generator.
// Each following word is compared against the locally predicted word, and
// bit/word error statistics are accumulated. Lock is dropped after LOSS_WORDS
// consecutive words that each have LOSS_THRESH or more bit errors.
//
// State  | meaning
// -------+-----------------------------------------------------------
// IDLE   | unlocked, waiting for an SOF word with a non-zero seed
// RUN    | locked, comparing every non-SOF word against the prediction
//
// Parameters
//   LOSS_THRESH     per-word bit-error count at or above which a word is bad
//   LOSS_WORDS      consecutive bad words that drop lock
//
// Ports
//   s_axi_aclk      clock, rising edge
//   s_axi_aresetn   asynchronous active-low reset
//   s_axis_tvalid   word valid
//   s_axis_tready   checker ready (low in reset, and while clear is high)
//   s_axis_sof      start of frame, qualified by tvalid
//   s_axis_tdata    decrypted PRBS word
//   clear           synchronous clear of counters and lock
//   locked          high in RUN
//   frame_count     SOF words accepted (saturating)
//   word_count      words compared (saturating)
//   err_bits        mismatched bits (saturating add)
//   err_words       words with at least one mismatched bit (saturating)
//   lock_loss_count RUN-to-IDLE drops caused by errors (saturating)
// -----------------------------------------------------------------------------
module prbs_frame_checker #(
    parameter int unsigned LOSS_THRESH = 8,
    parameter int unsigned LOSS_WORDS  = 4
) (
    input  logic        s_axi_aclk,
    input  logic        s_axi_aresetn,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_sof,
    input  logic [31:0] s_axis_tdata,
    input  logic        clear,
    output logic        locked,
    output logic [15:0] frame_count,
    output logic [31:0] word_count,
    output logic [31:0] err_bits,
    output logic [31:0] err_words,
    output logic [15:0] lock_loss_count
);

    localparam int unsigned BAD_W = $clog2(LOSS_WORDS + 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic             ready_q;
    logic [31:0]      seed_q, seed_d;
    logic [BAD_W-1:0] bad_q, bad_d, bad_inc;
    logic [15:0]      frame_d, loss_d;
    logic [31:0]      word_d, errb_d, errw_d;

    logic [63:0]      hist;
    logic [31:0]      predicted;
    logic [31:0]      diff;
    logic [5:0]       err_cnt;
    logic [32:0]      errb_sum;
    logic             hs;
    logic             bad_word;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    // ready_q holds tready low until the first edge after reset release.
    assign s_axis_tready = ready_q & ~clear;
    assign hs            = s_axis_tvalid & s_axis_tready;
    assign locked        = (state_q == ST_RUN);

    // Extend the 32-bit history by 32 more bits. hist[63] is the oldest bit;
    // bit b[32+i] lands at hist[31-i] and depends on b[1+i] and b[4+i], which
    // are at most 31 positions older, so each step only reads bits already
    // produced.
    always_comb begin
        hist = {seed_q, 32'd0};
        for (int i = 0; i < 32; i++) begin
            hist[31-i] = hist[62-i] ^ hist[59-i];
        end
        predicted = hist[31:0];
    end

    assign diff = s_axis_tdata ^ predicted;

    always_comb begin
        err_cnt = '0;
        for (int i = 0; i < 32; i++) begin
            err_cnt = err_cnt + {5'd0, diff[i]};
        end
    end

    assign errb_sum = {1'b0, err_bits} + {27'd0, err_cnt};
    assign bad_word = (32'(err_cnt) >= LOSS_THRESH);
    assign bad_inc  = bad_q + 1'b1;

    always_comb begin
        state_d = state_q;
        seed_d  = seed_q;
        bad_d   = bad_q;
        frame_d = frame_count;
        word_d  = word_count;
        errb_d  = err_bits;
        errw_d  = err_words;
        loss_d  = lock_loss_count;

        if (clear) begin
            state_d = ST_IDLE;
            bad_d   = '0;
            frame_d = '0;
            word_d  = '0;
            errb_d  = '0;
            errw_d  = '0;
            loss_d  = '0;
        end else if (hs) begin
            if (s_axis_sof) begin
                // Reseed in either state; a zero seed would lock the generator
                // at all-zeros, so it leaves the checker unlocked.
                frame_d = sat_inc16(frame_count);
                seed_d  = s_axis_tdata;
                bad_d   = '0;
                state_d = (s_axis_tdata != 32'd0) ? ST_RUN : ST_IDLE;
            end else if (state_q == ST_RUN) begin
                word_d = sat_inc32(word_count);
                errb_d = errb_sum[32] ? 32'hFFFF_FFFF : errb_sum[31:0];
                if (err_cnt != 6'd0) begin
                    errw_d = sat_inc32(err_words);
                end
                // Always advance on the prediction so a corrupted word never
                // pollutes the generator.
                seed_d = predicted;
                if (bad_word) begin
                    if (32'(bad_inc) >= LOSS_WORDS) begin
                        state_d = ST_IDLE;
                        bad_d   = '0;
                        loss_d  = sat_inc16(lock_loss_count);
                    end else begin
                        bad_d = bad_inc;
                    end
                end else begin
                    bad_d = '0;
                end
            end
        end
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state_q         <= ST_IDLE;
            ready_q         <= 1'b0;
            seed_q          <= '0;
            bad_q           <= '0;
            frame_count     <= '0;
            word_count      <= '0;
            err_bits        <= '0;
            err_words       <= '0;
            lock_loss_count <= '0;
        end else begin
            state_q         <= state_d;
            ready_q         <= 1'b1;
            seed_q          <= seed_d;
            bad_q           <= bad_d;
            frame_count     <= frame_d;
            word_count      <= word_d;
            err_bits        <= errb_d;
            err_words       <= errw_d;
            lock_loss_count <= loss_d;
        end
    end

endmodule

// File: tb/tb_prbs_frame_checker.sv
// -----------------------------------------------------------------------------
// tb_prbs_frame_checker
//
// Directed and randomized stimulus against a bit-serial PRBS31 reference model
// that keeps the generated sequence as a queue of bits.
// -----------------------------------------------------------------------------
module tb_prbs_frame_checker;

    localparam int THRESH = 8;
    localparam int LWORDS = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tvalid = 1'b0;
    logic        tready;
    logic        sof = 1'b0;
    logic [31:0] tdata = '0;
    logic        clear = 1'b0;
    logic        locked;
    logic [15:0] frame_count;
    logic [31:0] word_count;
    logic [31:0] err_bits;
    logic [31:0] err_words;
    logic [15:0] lock_loss_count;

    int n_tests = 0;
    int n_failed = 0;

    // reference model state
    bit          mq[$];
    logic        m_ready = 1'b0;
    logic        m_locked = 1'b0;
    logic [15:0] m_frame = '0;
    logic [31:0] m_word = '0;
    logic [31:0] m_errb = '0;
    logic [31:0] m_errw = '0;
    logic [15:0] m_loss = '0;
    int          m_bad = 0;

    prbs_frame_checker #(
        .LOSS_THRESH(THRESH),
        .LOSS_WORDS (LWORDS)
    ) dut (
        .s_axi_aclk     (clk),
        .s_axi_aresetn  (rst_n),
        .s_axis_tvalid  (tvalid),
        .s_axis_tready  (tready),
        .s_axis_sof     (sof),
        .s_axis_tdata   (tdata),
        .clear          (clear),
        .locked         (locked),
        .frame_count    (frame_count),
        .word_count     (word_count),
        .err_bits       (err_bits),
        .err_words      (err_words),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"},    32'(locked),          32'(m_locked));
        chk({tag, ".frame"},     32'(frame_count),     32'(m_frame));
        chk({tag, ".words"},     word_count,           m_word);
        chk({tag, ".err_bits"},  err_bits,             m_errb);
        chk({tag, ".err_words"}, err_words,            m_errw);
        chk({tag, ".loss"},      32'(lock_loss_count), 32'(m_loss));
    endtask

    function automatic void model_load(input logic [31:0] w);
        mq.delete();
        for (int k = 31; k >= 0; k--) mq.push_back(w[k]);
    endfunction

    // next 32 bits of the sequence, earliest bit in [31]
    function automatic logic [31:0] model_predict();
        bit h[$];
        logic [31:0] w;
        h = mq;
        for (int k = 0; k < 32; k++) begin
            h.push_back(h[h.size()-31] ^ h[h.size()-28]);
            w[31-k] = h[h.size()-1];
        end
        return w;
    endfunction

    function automatic void model_reset();
        m_ready = 1'b0; m_locked = 1'b0; m_frame = '0; m_word = '0;
        m_errb = '0; m_errw = '0; m_loss = '0; m_bad = 0;
        model_load(32'd0);
    endfunction

    task automatic model_edge(input logic v, input logic s, input logic [31:0] d, input logic clr);
        logic [31:0] p;
        int err;
        if (clr) begin
            m_locked = 1'b0; m_frame = '0; m_word = '0; m_errb = '0;
            m_errw = '0; m_loss = '0; m_bad = 0; m_ready = 1'b1;
            return;
        end
        if (!m_ready) begin
            m_ready = 1'b1;
            return;
        end
        if (!v) return;
        if (s) begin
            if (m_frame != 16'hFFFF) m_frame = m_frame + 16'd1;
            m_bad = 0;
            if (d != 32'd0) begin
                model_load(d);
                m_locked = 1'b1;
            end else begin
                m_locked = 1'b0;
            end
        end else if (m_locked) begin
            p = model_predict();
            err = $countones(d ^ p);
            if (m_word != 32'hFFFF_FFFF) m_word = m_word + 32'd1;
            if (longint'(m_errb) + longint'(err) > 64'hFFFF_FFFF) m_errb = 32'hFFFF_FFFF;
            else m_errb = m_errb + 32'(err);
            if (err != 0 && m_errw != 32'hFFFF_FFFF) m_errw = m_errw + 32'd1;
            model_load(p);
            if (err >= THRESH) begin
                m_bad++;
                if (m_bad >= LWORDS) begin
                    m_locked = 1'b0;
                    m_bad = 0;
                    if (m_loss != 16'hFFFF) m_loss = m_loss + 16'd1;
                end
            end else begin
                m_bad = 0;
            end
        end
    endtask

    // one clock cycle: drive, check tready before the edge, check outputs after
    task automatic cyc(input logic v, input logic s, input logic [31:0] d, input logic clr, input string tag);
        tvalid = v; sof = s; tdata = d; clear = clr;
        #1;
        chk({tag, ".tready"}, 32'(tready), 32'(m_ready && !clr));
        @(posedge clk);
        model_edge(v, s, d, clr);
        #1;
        tvalid = 1'b0; clear = 1'b0;
        check_all(tag);
    endtask

    function automatic logic [31:0] nz_seed();
        logic [31:0] s;
        s = $urandom;
        if (s == 32'd0) s = 32'h1234_5678;
        return s;
    endfunction

    initial begin
        logic        v, s, c;
        logic [31:0] d, w;

        model_reset();

        // power-on reset, held across an edge
        #3;
        chk("por.tready", 32'(tready), 32'd0);
        check_all("por");
        @(posedge clk); #1;
        check_all("por_edge");
        #5;
        rst_n = 1'b1;
        #1;
        chk("por_rel.tready", 32'(tready), 32'd0);

        // words before any SOF are discarded, tdata/sof wiggling with tvalid low
        for (int i = 0; i < 6; i++) cyc(1'b1, 1'b0, $urandom, 1'b0, "pre_sof");
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, nz_seed(), 1'b0, "no_valid");
        cyc(1'b1, 1'b0, $urandom, 1'b0, "pre_sof2");
        cyc(1'b1, 1'b1, 32'd0, 1'b0, "zero_sof");
        chk("zero_sof.frame_c", 32'(frame_count), 32'd1);
        chk("zero_sof.locked_c", 32'(locked), 32'd0);
        chk("zero_sof.words_c", word_count, 32'd0);

        // known vector: all-ones seed predicts 0x0000000E
        cyc(1'b0, 1'b0, 32'd0, 1'b1, "clr_a");
        cyc(1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, "ones_sof");
        cyc(1'b1, 1'b0, 32'h0000_000E, 1'b0, "ones_w1");
        chk("kv.locked", 32'(locked), 32'd1);
        chk("kv.frame", 32'(frame_count), 32'd1);
        chk("kv.words", word_count, 32'd1);
        chk("kv.err_bits", err_bits, 32'd0);
        chk("kv.err_words", err_words, 32'd0);

        // 100 words, single bit flip in word 50, random idle gaps
        cyc(1'b0, 1'b0, 32'd0, 1'b1, "clr_b");
        cyc(1'b1, 1'b1, nz_seed(), 1'b0, "run100_sof");
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 3) == 0) cyc(1'b0, $urandom_range(0, 1) == 1, $urandom, 1'b0, "run100_gap");
            w = model_predict();
            if (i == 50) w = w ^ 32'h0000_0020;
            cyc(1'b1, 1'b0, w, 1'b0, "run100");
        end
        chk("run100.words", word_count, 32'd100);
        chk("run100.err_bits", err_bits, 32'd1);
        chk("run100.err_words", err_words, 32'd1);
        chk("run100.locked", 32'(locked), 32'd1);

        // just below threshold never drops lock
        for (int i = 0; i < 6; i++)
            cyc(1'b1, 1'b0, model_predict() ^ (32'h7F << $urandom_range(0, 25)), 1'b0, "below_thr");
        chk("below_thr.locked", 32'(locked), 32'd1);

        // four bad words drop lock on the fourth
        cyc(1'b0, 1'b0, 32'd0, 1'b1, "clr_c");
        cyc(1'b1, 1'b1, nz_seed(), 1'b0, "loss_sof");
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, model_predict() ^ (32'hFF << $urandom_range(0, 24)), 1'b0, "loss_bad");
            if (i == 2) chk("loss.still_locked", 32'(locked), 32'd1);
        end
        chk("loss.locked", 32'(locked), 32'd0);
        chk("loss.count", 32'(lock_loss_count), 32'd1);
        chk("loss.err_bits", err_bits, 32'd32);
        // relock: 3 bad, 1 good, 3 bad keeps lock
        cyc(1'b1, 1'b1, nz_seed(), 1'b0, "relock_sof");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, model_predict() ^ (32'hFF << $urandom_range(0, 24)), 1'b0, "relock_bad");
        cyc(1'b1, 1'b0, model_predict(), 1'b0, "relock_good");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, model_predict() ^ (32'hFF << $urandom_range(0, 24)), 1'b0, "relock_bad2");
        chk("relock.locked", 32'(locked), 32'd1);
        chk("relock.loss", 32'(lock_loss_count), 32'd1);
        // SOF reseed also clears the bad-word run
        cyc(1'b1, 1'b1, nz_seed(), 1'b0, "reseed_sof");
        for (int i = 0; i < 3; i++)
            cyc(1'b1, 1'b0, model_predict() ^ (32'hFF << $urandom_range(0, 24)), 1'b0, "reseed_bad");
        chk("reseed.locked", 32'(locked), 32'd1);

        // clear during a handshake while locked with gaps
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 2) == 0) cyc(1'b0, 1'b0, $urandom, 1'b0, "clr_gap");
            cyc(1'b1, 1'b0, model_predict(), 1'b0, "clr_run");
        end
        cyc(1'b1, 1'b0, model_predict(), 1'b1, "clr_hs");
        chk("clr_hs.words", word_count, 32'd0);
        chk("clr_hs.locked", 32'(locked), 32'd0);
        chk("clr_hs.frame", 32'(frame_count), 32'd0);

        // randomized mix
        cyc(1'b1, 1'b1, nz_seed(), 1'b0, "rnd_sof");
        for (int n = 0; n < 400; n++) begin
            v = ($urandom_range(0, 3) != 0);
            s = ($urandom_range(0, 24) == 0);
            c = ($urandom_range(0, 59) == 0);
            if (s) begin
                d = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            end else if (m_locked) begin
                case ($urandom_range(0, 5))
                    0, 1:    d = model_predict();
                    2:       d = model_predict() ^ (32'h1 << $urandom_range(0, 31));
                    3, 4:    d = model_predict() ^ (32'hFF << $urandom_range(0, 24));
                    default: d = $urandom;
                endcase
            end else begin
                d = $urandom;
            end
            cyc(v, s, d, c, "rnd");
        end

        // asynchronous reset mid-frame, between clock edges
        cyc(1'b1, 1'b1, nz_seed(), 1'b0, "ar_sof");
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, model_predict(), 1'b0, "ar_run");
        tvalid = 1'b1; sof = 1'b0; tdata = model_predict();
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("ar.tready", 32'(tready), 32'd0);
        check_all("ar");
        @(posedge clk); #1;
        check_all("ar_edge");
        #5;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, $urandom, 1'b0, "ar_after");
        chk("ar_after.locked", 32'(locked), 32'd0);
        chk("ar_after.words", word_count, 32'd0);
        cyc(1'b1, 1'b1, nz_seed(), 1'b0, "ar_relock");
        chk("ar_relock.locked", 32'(locked), 32'd1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, model_predict(), 1'b0, "ar_relock_run");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_failed);
        $finish;
    end

endmodule
